// File: rtl/intr_cntrl_pkg.sv
// intr_cntrl_pkg: shared sizes, vector field offsets and read-select encodings
package intr_cntrl_pkg;
    localparam int NUM_IRQ   = 32;
    localparam int NUM_CORE  = 4;
    localparam int VALID_BIT = 7;
    localparam int PRIO_LSB  = 5;
    localparam int ID_LSB    = 0;
    typedef enum logic [1:0] {
        SEL_CLAIM = 2'b00,
        SEL_IRR   = 2'b01,
        SEL_IMR   = 2'b10,
        SEL_ISR   = 2'b11
    } sel_e;
endpackage

// File: rtl/intr_prio_resolver.sv
// intr_prio_resolver: picks the highest-priority eligible source, higher index wins ties
module intr_prio_resolver
    import intr_cntrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0]   eligible,
    input  logic [2*NUM_IRQ-1:0] prio_cnfg,
    output logic                 valid,
    output logic [4:0]           id,
    output logic [1:0]           prio
);
    // later matches overwrite earlier ones, so the last hit is highest level then highest index
    always_comb begin
        valid = 1'b0;
        id    = '0;
        prio  = '0;
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < NUM_IRQ; i++)
                if (eligible[i] && prio_cnfg[2*i +: 2] == 2'(l)) begin
                    valid = 1'b1;
                    id    = 5'(i);
                    prio  = 2'(l);
                end
    end
endmodule

// File: rtl/intr_cntrl.sv
// intr_cntrl: 32-source, 4-core interrupt controller with broadcast request and first-ack claim
module intr_cntrl
    import intr_cntrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic [NUM_IRQ-1:0]   imq,
    input  logic [2*NUM_IRQ-1:0] prio_cnfg,
    input  logic                 read,
    input  logic [1:0]           s,
    input  logic                 int_ack1,
    input  logic                 int_ack2,
    input  logic                 int_ack3,
    input  logic                 int_ack4,
    output logic                 int_req1,
    output logic                 int_req2,
    output logic                 int_req3,
    output logic                 int_req4,
    output logic [31:0]          data_bus1,
    output logic [31:0]          data_bus2,
    output logic [31:0]          data_bus3,
    output logic [31:0]          data_bus4
);
    logic [NUM_IRQ-1:0]  r_irr, r_imr, r_isr;
    logic [31:0]         r_claim [NUM_CORE];
    logic [NUM_IRQ-1:0]  w_elig, w_set;
    logic                w_valid, w_req;
    logic [4:0]          w_id;
    logic [1:0]          w_prio;
    logic [31:0]         w_vec;
    logic [NUM_CORE-1:0] w_ack, w_grant;
    logic [31:0]         w_bus [NUM_CORE];

    assign w_elig = r_irr & r_imr & ~r_isr;

    intr_prio_resolver u_res (
        .eligible (w_elig),
        .prio_cnfg(prio_cnfg),
        .valid    (w_valid),
        .id       (w_id),
        .prio     (w_prio)
    );

    assign w_vec   = w_valid ? (32'(1) << VALID_BIT) | (32'(w_prio) << PRIO_LSB) | (32'(w_id) << ID_LSB) : '0;
    assign w_ack   = {int_ack4, int_ack3, int_ack2, int_ack1};
    // isolate the lowest-numbered acking core
    assign w_grant = w_valid ? (w_ack & (~w_ack + 4'd1)) : '0;
    assign w_set   = |w_grant ? (32'(1) << w_id) : '0;
    assign w_req   = |w_elig;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irr <= '0;
            r_imr <= '0;
            r_isr <= '0;
            for (int c = 0; c < NUM_CORE; c++) r_claim[c] <= '0;
        end else begin
            r_irr <= irq;
            r_imr <= imq;
            r_isr <= (r_isr | w_set) & r_irr;
            for (int c = 0; c < NUM_CORE; c++)
                if (w_grant[c]) r_claim[c] <= w_vec;
        end
    end

    for (genvar c = 0; c < NUM_CORE; c++) begin : g_bus
        assign w_bus[c] = !read            ? w_vec      :
                          s == SEL_CLAIM   ? r_claim[c] :
                          s == SEL_IRR     ? r_irr      :
                          s == SEL_IMR     ? r_imr      : r_isr;
    end

    assign {int_req4, int_req3, int_req2, int_req1} = {4{w_req}};
    assign data_bus1 = w_bus[0];
    assign data_bus2 = w_bus[1];
    assign data_bus3 = w_bus[2];
    assign data_bus4 = w_bus[3];
endmodule

// File: tb/tb_intr_cntrl.sv
// tb_intr_cntrl: directed vectors for dispatch order, claim arbitration, masking and read-back
module tb_intr_cntrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] irq, imq;
    logic [63:0] prio_cnfg;
    logic        read;
    logic [1:0]  s;
    logic [3:0]  ack;
    wire  [3:0]  req;
    wire  [31:0] bus [4];
    int          checks = 0;
    int          errors = 0;

    int ids   [11] = '{31, 6, 0, 14, 9, 1, 7, 2, 13, 10, 3};
    int prs   [11] = '{3, 3, 3, 2, 2, 2, 1, 1, 0, 0, 0};
    int cores [11] = '{1, 2, 1, 4, 3, 2, 4, 1, 2, 3, 4};

    always #5 clk = ~clk;

    intr_cntrl dut (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .imq      (imq),
        .prio_cnfg(prio_cnfg),
        .read     (read),
        .s        (s),
        .int_ack1 (ack[0]),
        .int_ack2 (ack[1]),
        .int_ack3 (ack[2]),
        .int_ack4 (ack[3]),
        .int_req1 (req[0]),
        .int_req2 (req[1]),
        .int_req3 (req[2]),
        .int_req4 (req[3]),
        .data_bus1(bus[0]),
        .data_bus2(bus[1]),
        .data_bus3(bus[2]),
        .data_bus4(bus[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] vec(input int p, input int i);
        return 32'h80 | 32'(p << 5) | 32'(i);
    endfunction

    task automatic check_all(input string tag, input logic [31:0] exp);
        for (int c = 0; c < 4; c++) check(tag, bus[c], exp);
    endtask

    initial begin
        reset = 1'b0; irq = '0; imq = '0; prio_cnfg = '0; read = 1'b0; s = 2'b00; ack = '0;
        tick(10);
        reset = 1'b1;
        tick(2);
        check("rst_req", 32'(req), 32'h0);
        check_all("rst_bus", 32'h0);

        prio_cnfg = 64'hC0000000_2008701B;
        imq = 32'hFFFF_FFFF;
        irq = 32'h8000_66CF;
        tick(2);
        for (int k = 0; k < 11; k++) begin
            check("req_on", 32'(req), 32'hF);
            check_all("winner", vec(prs[k], ids[k]));
            ack[cores[k]-1] = 1'b1;
            irq[ids[k]] = 1'b0;
            tick();
            ack = '0;
            read = 1'b1; s = 2'b00;
            #1;
            check("claim", bus[cores[k]-1], vec(prs[k], ids[k]));
            read = 1'b0;
            tick(3);
        end
        check("drained_req", 32'(req), 32'h0);
        check("drained_vec", bus[0], 32'h0);

        irq = 32'h8; imq = ~32'h8;
        tick(2);
        check("masked_req", 32'(req), 32'h0);
        check("masked_vec", bus[0], 32'h0);
        imq = 32'hFFFF_FFFF;
        tick();
        check("unmask_vec", bus[1], 32'h83);
        check("unmask_req", 32'(req), 32'hF);

        irq = 32'h8000_0000;
        tick(2);
        check("w31", bus[0], 32'hFF);
        ack = 4'b0110;
        tick();
        ack = '0;
        read = 1'b1; s = 2'b00;
        #1;
        check("claim2", bus[1], 32'hFF);
        check("claim3", bus[2], 32'h8A);
        check("claim1", bus[0], 32'hA2);
        s = 2'b11;
        #1;
        check("isr31", bus[0], 32'h8000_0000);
        read = 1'b0;
        #1;
        check("w31_gone", 32'(req), 32'h0);
        irq = '0;
        tick(2);

        irq = 32'h20;
        tick(2);
        check("w5", bus[0], 32'h85);
        ack = 4'b0001;
        tick();
        ack = '0;
        #1;
        check("held_req", 32'(req), 32'h0);
        tick(3);
        check("held_vec", bus[2], 32'h0);
        irq = '0;
        tick();
        irq = 32'h20;
        tick();
        check("redispatch", bus[3], 32'h85);
        check("redisp_req", 32'(req), 32'hF);

        ack = 4'b1000;
        tick();
        ack = '0;
        irq = 32'h120; imq = 32'h1234_FFF0;
        tick();
        read = 1'b1;
        s = 2'b01; #1; check_all("rd_irr", 32'h120);
        s = 2'b10; #1; check_all("rd_imr", 32'h1234_FFF0);
        s = 2'b11; #1; check_all("rd_isr", 32'h20);
        s = 2'b00; #1; check("rd_claim4", bus[3], 32'h85);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        s = 2'b11; #1; check("rst_isr", bus[0], 32'h0);
        s = 2'b00; #1; check_all("rst_claim", 32'h0);
        read = 1'b0; #1;
        check("rst_req2", 32'(req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
